mdu_unit: RTL
=============

# mdu_unit

Parametrised iterative multiply/divide unit for the RV32M subset of the RV32IM pipeline's execute stage. It sits beside `alu` and takes over the eight M-extension operations that need more than one cycle. A shift-add multiplier and a restoring divider share one WIDTH-step datapath. The pipeline stalls on BUSY and writes back RESULT when RESULT_VALID pulses.

## Interface
- WIDTH, 32, operand/result width in bits; must be ≥ 4.
- CLK  input  1  clock, all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request; sampled only when the unit is idle (BUSY=0).
- KILL  input  1  pipeline flush; aborts any in-flight operation.
- OPCODE  input  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- DATA1  input  WIDTH  rs1 operand (multiplicand / dividend).
- DATA2  input  WIDTH  rs2 operand (multiplier / divisor).
- RESULT  output  WIDTH  registered result; holds until the next completion.
- BUSY  output  1  operation in flight; new START ignored.
- RESULT_VALID  output  1  one-cycle pulse, RESULT is valid this cycle.

## Operation
- States: IDLE, CALC, FIX.
- IDLE + START=1 + KILL=0: latch OPCODE, operand magnitudes and sign flags, clear the step counter. Special case goes to FIX. Otherwise go to CALC.
- Signedness: MUL/MULH/DIV/REM treat both operands as signed. MULHSU treats DATA1 as signed and DATA2 as unsigned. The rest are unsigned.
- CALC: one step per cycle for exactly WIDTH cycles.
  - Multiply: add the multiplicand to the 2·WIDTH accumulator if the current multiplier bit is 1, then shift.
  - Divide: shift the remainder left, trial-subtract the divisor, set the quotient bit on success.
  - After step WIDTH-1, go to FIX.
- FIX: apply signs and register RESULT, then go to IDLE.
  - Product is negated if the operand signs differ; MUL returns the low WIDTH bits, MULH* the high WIDTH bits.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
- Special cases are resolved at START with no CALC phase:
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return DATA1.
  - Signed overflow (DATA1 = 1 followed by WIDTH-1 zeros, DATA2 all ones): DIV returns DATA1; REM returns 0.
- KILL=1 in any state: return to IDLE next edge, no RESULT_VALID, RESULT unchanged. KILL has priority over START.
- RESET=1: state IDLE, RESULT=0, BUSY=0, RESULT_VALID=0, counter=0. Reset mid-operation discards the operation with no pulse.
- START while BUSY=1 is ignored; the operands are not re-sampled.

## Timing
- Let edge 0 be the edge at which START is accepted.
- Iterative ops:
  - BUSY=1 after edge 0 through edge WIDTH+1.
  - RESULT_VALID=1 for the single cycle after edge WIDTH+1, with BUSY=0 in that cycle.
  - Latency is WIDTH+2 cycles (34 for WIDTH=32).
- Special cases: FIX entered at edge 0; RESULT_VALID=1 after edge 1 (latency 2).
- Back-to-back: START may be asserted in the RESULT_VALID cycle and is accepted at that edge.
- RESULT is only updated at the FIX→IDLE edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- MDU_FAST_MUL_EN defined:
  - The four multiply ops use a single-cycle combinational WIDTH×WIDTH product and go IDLE→FIX directly, with latency 2 like the special cases.
  - Divides are unchanged.
- MDU_FAST_MUL_EN undefined: all multiplies use the iterative path (WIDTH+2 cycles).
- The bench reads the macro and checks the corresponding latency.

## Test plan
- MUL, DATA1=6, DATA2=3, WIDTH=32 -> RESULT=18 with RESULT_VALID exactly 34 cycles after START (2 cycles with MDU_FAST_MUL_EN); BUSY high for the preceding 33 cycles.
- MULH 0xFFFFFFFF×0xFFFFFFFF -> 0x00000000. MULHU same operands -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0x00000002 -> 0xFFFFFFFF.
- DIV −7/2 -> 0xFFFFFFFD. REM −7/2 -> 0xFFFFFFFF. DIVU 6/3 -> 2. REMU 7/3 -> 1.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with RESULT_VALID 2 cycles after START. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- KILL asserted 10 cycles into a DIV -> BUSY low next cycle, no RESULT_VALID pulse, RESULT keeps its prior value. RESET mid-MUL -> RESULT=0, no pulse.
- START with new operands while BUSY -> ignored, the original result is returned. START in the RESULT_VALID cycle -> second op accepted, its result appears 34 cycles later.

Source files
------------

// File: rtl/mdu_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_unit_if
//  Description : Request/response bundle between the execute stage and mdu_unit.
//  Revision    : 1.0
// ============================================================================
interface mdu_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             kill;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             result_valid;

  modport master (
    output start, kill, opcode, data1, data2,
    input  result, busy, result_valid
  );

  modport slave (
    input  start, kill, opcode, data1, data2,
    output result, busy, result_valid
  );
endinterface
`default_nettype wire

// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_unit
//  Description : Iterative RV32M multiply/divide unit (shift-add multiplier,
//                restoring divider). Define MDU_FAST_MUL_EN for 2-cycle
//                combinational multiplies.
//  Revision    : 1.0
// ============================================================================
module mdu_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic   clk,
  input  wire logic   rst,
  mdu_unit_if.slave   mdu_bus
);

  localparam int c_CW = $clog2(WIDTH);
  localparam logic [c_CW-1:0]  c_LAST = c_CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] c_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_FIX  = 2'd2;

  logic [1:0]         r_state;
  logic [2:0]         r_op;
  logic [c_CW-1:0]    r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_neg;
  logic               r_neg_rem;
  logic               r_special;
  logic [WIDTH-1:0]   r_result;
  logic               r_busy;
  logic               r_valid;

  logic               w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic               w_div0, w_ovf, w_special;
  logic [WIDTH-1:0]   w_special_val;
  logic [WIDTH:0]     w_mul_sum, w_trial;
  logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_prod;
  logic [WIDTH-1:0]   w_quot, w_rem, w_fix;

  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (mdu_bus.opcode)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      3'b010:  w_a_signed = 1'b1;
      default: ;
    endcase
    w_a_neg = w_a_signed & mdu_bus.data1[WIDTH-1];
    w_b_neg = w_b_signed & mdu_bus.data2[WIDTH-1];
    w_a_mag = w_a_neg ? -mdu_bus.data1 : mdu_bus.data1;
    w_b_mag = w_b_neg ? -mdu_bus.data2 : mdu_bus.data2;

    // Degenerate divides are answered directly, skipping the iteration
    w_div0 = mdu_bus.opcode[2] & (mdu_bus.data2 == '0);
    w_ovf  = mdu_bus.opcode[2] & ~mdu_bus.opcode[0] &
             (mdu_bus.data1 == c_MIN) & (mdu_bus.data2 == '1);
    w_special = w_div0 | w_ovf;
    if (w_div0)
      w_special_val = mdu_bus.opcode[1] ? mdu_bus.data1 : '1;
    else
      w_special_val = mdu_bus.opcode[1] ? '0 : mdu_bus.data1;
  end

  // Multiply: multiplier sits in the low half and is consumed from bit 0.
  // Divide: {remainder, quotient} shifts left with the dividend feeding in.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_a};
    w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};
    w_trial    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_a};
    w_div_next = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    w_prod = r_neg ? -r_acc : r_acc;
    w_quot = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    w_fix  = '0;
    if (r_special) begin
      w_fix = r_acc[WIDTH-1:0];
    end else begin
      case (r_op)
        3'b000:                 w_fix = w_prod[WIDTH-1:0];
        3'b001, 3'b010, 3'b011: w_fix = w_prod[2*WIDTH-1:WIDTH];
        3'b100, 3'b101:         w_fix = w_quot;
        default:                w_fix = w_rem;
      endcase
    end
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_prod;
  assign w_fast_prod = {{WIDTH{1'b0}}, w_a_mag} * {{WIDTH{1'b0}}, w_b_mag};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_IDLE;
      r_op      <= '0;
      r_cnt     <= '0;
      r_a       <= '0;
      r_acc     <= '0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_special <= 1'b0;
      r_result  <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
    end else if (mdu_bus.kill) begin
      r_state <= c_IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (mdu_bus.start) begin
            r_op      <= mdu_bus.opcode;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_neg     <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_special <= w_special;
            if (mdu_bus.opcode[2]) begin
              r_a   <= w_b_mag;
              r_acc <= {{WIDTH{1'b0}}, w_a_mag};
            end else begin
              r_a   <= w_a_mag;
              r_acc <= {{WIDTH{1'b0}}, w_b_mag};
            end
            if (w_special) begin
              r_acc   <= {{WIDTH{1'b0}}, w_special_val};
              r_state <= c_FIX;
            end
`ifdef MDU_FAST_MUL_EN
            else if (!mdu_bus.opcode[2]) begin
              r_acc   <= w_fast_prod;
              r_state <= c_FIX;
            end
`endif
            else begin
              r_state <= c_CALC;
            end
          end
        end
        c_CALC: begin
          r_acc <= r_op[2] ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + c_CW'(1);
          if (r_cnt == c_LAST)
            r_state <= c_FIX;
        end
        c_FIX: begin
          r_result <= w_fix;
          r_valid  <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign mdu_bus.result       = r_result;
  assign mdu_bus.busy         = r_busy;
  assign mdu_bus.result_valid = r_valid;

endmodule
`default_nettype wire
